// File: rtl/cfg_bitstream_loader.sv
// Configuration loader: synchronizes pin strobes, packs 4-bit nibbles MS-first
// into DATA_WIDTH words, buffers them in a 2-entry FIFO, emits AXI-Stream frames.
// Ports: clk, rst_n (async low), in_nibble/in_strobe (pins), ld_abort (sync flush),
//        cfg (frame-start pulse), cfg_bitstream_t* (AXI-Stream master), busy, err.
module cfg_bitstream_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_nibble,
    input  logic                  in_strobe,
    input  logic                  ld_abort,
    output logic                  cfg,
    output logic [DATA_WIDTH-1:0] cfg_bitstream_tdata,
    output logic                  cfg_bitstream_tvalid,
    input  logic                  cfg_bitstream_tready,
    output logic                  cfg_bitstream_tlast,
    output logic                  busy,
    output logic                  err
);

    localparam int NIBS = DATA_WIDTH / 4;
    localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int BW   = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [NW-1:0] NIB_LAST  = NW'(NIBS - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    logic [NW-1:0]         nib_cnt_q, nib_cnt_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  cfg_q, cfg_d;
    logic                  err_q, err_d;

    logic [1:0][DATA_WIDTH:0] mem_q, mem_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic [1:0]               count_q, count_d;

    logic                  cap;
    logic                  word_done;
    logic                  is_last;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] word_nxt;

    always_comb begin
        sync1_d    = in_strobe;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        beat_cnt_d = beat_cnt_q;
        word_d     = word_q;
        cfg_d      = 1'b0;
        err_d      = err_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;

        cap       = sync2_q & ~sync3_q;
        word_done = (nib_cnt_q == NIB_LAST);
        is_last   = (beat_cnt_q == BEAT_LAST);
        full      = (count_q == 2'd2);
        pop       = (count_q != 2'd0) & cfg_bitstream_tready;
        // Shift-in packing leaves the first nibble in the MS position.
        word_nxt  = (word_q << 4) | DATA_WIDTH'(in_nibble);

        if (ld_abort) begin
            state_d    = S_IDLE;
            nib_cnt_d  = '0;
            beat_cnt_d = '0;
            word_d     = '0;
            err_d      = 1'b0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            unique case (state_q)
                S_IDLE, S_LOAD: begin
                    if (cap) begin
                        if (state_q == S_IDLE) begin
                            cfg_d = 1'b1;
                        end
                        state_d = S_LOAD;
                        word_d  = word_nxt;
                        if (!word_done) begin
                            nib_cnt_d = nib_cnt_q + 1'b1;
                        end else if (full && !pop) begin
                            // Overflow: drop the word, freeze counters.
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            push       = 1'b1;
                            nib_cnt_d  = '0;
                            beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
                            if (is_last) begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (push) begin
                mem_d[wr_ptr_q] = {is_last, word_nxt};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            nib_cnt_q  <= '0;
            beat_cnt_q <= '0;
            word_q     <= '0;
            cfg_q      <= 1'b0;
            err_q      <= 1'b0;
            mem_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            nib_cnt_q  <= nib_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            word_q     <= word_d;
            cfg_q      <= cfg_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    assign cfg                  = cfg_q;
    assign err                  = err_q;
    assign cfg_bitstream_tvalid = (count_q != 2'd0);
    assign {cfg_bitstream_tlast, cfg_bitstream_tdata} = mem_q[rd_ptr_q];
    assign busy = (state_q == S_LOAD) | cfg_bitstream_tvalid;

endmodule

// File: doc/cfg_bitstream_loader.md
# cfg_bitstream_loader

Front-end configuration loader. It collects 4-bit configuration nibbles strobed in from package pins, packs them into `DATA_WIDTH`-bit words, and buffers them in a 2-entry FIFO. It emits them as an AXI-Stream frame of `FRAME_BEATS` beats, with `tlast` on the final beat. It sits directly upstream of `tiny_fpga`: it drives that block's `cfg` request and `cfg_bitstream` slave port.

## Interface
- `DATA_WIDTH`, 8: AXI `tdata` width. Must be a multiple of 4 and ≥ 4. Must equal the width of the connected `axi_stream_if`.
- `FRAME_BEATS`, 4: beats per configuration frame. Must be ≥ 1.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_nibble`  in  4  pin data. The host holds it stable from strobe rise until strobe fall.
- `in_strobe`  in  1  pin strobe, asynchronous to `clk`. Each rising edge delivers one nibble.
- `ld_abort`  in  1  synchronous abort: flush everything and return to IDLE.
- `cfg`  out  1  one-cycle pulse at frame start; drives `tiny_fpga.cfg`.
- `cfg_bitstream`  `axi_stream_if.master`  uses `tdata[DATA_WIDTH]`, `tvalid`, `tready`, `tlast`.
- `busy`  out  1  high when state is LOAD, or the FIFO is non-empty.
- `err`  out  1  sticky overflow flag.

## Operation
- Strobe synchronizer:
  - 2-flop synchronizer on `in_strobe`, followed by a third flop for edge detection.
  - `cap` = sync2 & ~sync3.
  - `in_nibble` is sampled on the edge where `cap` is high.
- Packing:
  - The first nibble of a word goes to `tdata[DATA_WIDTH-1 -: 4]` (MS nibble first).
  - `nib_cnt` counts 0..DATA_WIDTH/4-1.
  - On the last nibble, the word plus a `last` bit (`beat_cnt == FRAME_BEATS-1`) is pushed into the FIFO.
  - The same edge clears `nib_cnt` and increments `beat_cnt`, which wraps to 0 after the last beat.
- FIFO:
  - 2 entries of {`last`, `data`}; the head drives `tdata`/`tlast`.
  - `tvalid` = FIFO non-empty.
  - Pop on `tvalid & tready`.
  - Push and pop in the same cycle are legal at any occupancy except the following: when full, a push is accepted only if a pop happens that cycle.
- States:
  - IDLE: on `cap`, capture the nibble, pulse `cfg`, and go to LOAD.
  - LOAD: accept nibbles. The push of the `last` word returns the state to IDLE.
  - ERROR: entered when a word completes while the FIFO is full with no simultaneous pop.
    - The word is dropped and `err` is set.
    - While in ERROR, `cap` is ignored and counters are frozen.
    - The FIFO keeps draining.
    - The only exits are `ld_abort` or reset.
- `ld_abort` (any state):
  - Next cycle: state IDLE, counters 0, FIFO empty, `err` cleared.
  - Sync flops are not cleared.
  - It has priority over a simultaneous `cap` and push; that nibble is discarded.
- Outputs only: the loader does not check `tready` behaviour beyond the AXI rules. A frame may straddle IDLE→LOAD while earlier beats are still draining.

## Timing
- Reset values:
  - `cfg`=0, `tvalid`=0, `tlast`=0, `tdata`=0.
  - `busy`=0, `err`=0.
  - State IDLE, counters 0, sync flops 0.
- Pin-to-capture latency: `in_nibble` is sampled on the 3rd rising `clk` edge at which `in_strobe` is high, counting its first sampled-high edge as edge 1.
- `cfg`: high for exactly the one cycle following the capture edge of the first nibble of a frame.
- Word to `tvalid`: `tvalid` rises in the cycle after the push edge of the final nibble, if the FIFO was empty.
- AXI rules:
  - Once `tvalid` is high, `tdata` and `tlast` are stable until the handshake.
  - `tvalid` never drops without a handshake, except on `ld_abort`.
- Strobe rate: minimum `in_strobe` high time is 2 clk periods, and minimum low time is 2 clk periods.
  - Narrower pulses may be missed; this is not flagged.
- `FRAME_BEATS`=1: every word carries `tlast`=1, and each word starts a new frame with its own `cfg` pulse.

## Test plan
- Basic frame:
  - Stimulus: defaults, `tready`=1, nibbles 1,2,3,4,5,6,7,8.
  - Required response: one `cfg` pulse after the first capture; beats 0x12, 0x34, 0x56, 0x78; `tlast` only on 0x78; `busy` returns to 0.
- Backpressure:
  - Stimulus: `tready`=0 until 2 words are buffered, then the 3rd word completes.
  - Required response: `err`=1; state ERROR; after `tready`=1, exactly 0x12 and 0x34 drain; further strobes produce nothing.
- Abort:
  - Stimulus: `ld_abort` mid-word, after nibble A only.
  - Required response: next cycle `tvalid`=0, `busy`=0, `err`=0; the next nibbles B,C give the word 0xBC with a fresh `cfg` pulse.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 asynchronously with `tvalid` high.
  - Required response: all outputs go to 0 immediately, without waiting for a clock edge.
- Latency:
  - Stimulus: a single strobe.
  - Required response: capture on the 3rd edge with strobe high; `cfg` in the following cycle. With `DATA_WIDTH`=4, `tvalid` also rises that cycle.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full; `tready`=1 on the same edge that completes a word.
  - Required response: no error; beat order is preserved.
